// File: rtl/mcu_trace_buffer.sv
// Execution trace recorder: samples {ts, state, pc, instr} into a circular
// buffer. It can log on change or every cycle, can wait for a PC trigger, and
// can either wrap or stop when full. A consumer drains the buffer through a
// show-ahead valid/ready port.
module mcu_trace_buffer #(
  parameter  int PC_W    = 8,
  parameter  int INSTR_W = 8,
  parameter  int STATE_W = 3,
  parameter  int TS_W    = 16,
  parameter  int DEPTH   = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int ENTRY_W = TS_W + STATE_W + PC_W + INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trace_en,
  input  logic               clear,
  input  logic               every_cyc,
  input  logic               wrap_en,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [PC_W-1:0]    pc,
  input  logic [STATE_W-1:0] state,
  input  logic [INSTR_W-1:0] instr,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [AW:0]        count,
  output logic               overflow,
  output logic [7:0]         dropped,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, STOPPED = 2'd3} fsm_t;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  fsm_t               fsm_q, fsm_d;
  logic [TS_W-1:0]    ts;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic               first;
  logic [STATE_W-1:0] last_state;
  logic [INSTR_W-1:0] last_instr;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic log_cycle, log_req, full, pop, wr_en, wr_over, wr_drop;

  // Free-running timestamp; only reset restarts it, clear does not.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts <= '0;
    else        ts <= ts + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // FSM next-state: clear beats everything, then loss of trace_en.
  // NOTE: default assignment first so no path leaves fsm_d unassigned (no latch).
  always_comb begin
    fsm_d = fsm_q;
    if (clear || !trace_en) begin
      fsm_d = IDLE;
    end else begin
      case (fsm_q)
        IDLE:    fsm_d = trig_en ? ARMED : CAPTURE;
        ARMED:   if (pc == trig_pc) fsm_d = CAPTURE;
        CAPTURE: if (wr_drop) fsm_d = STOPPED;
        default: fsm_d = fsm_q;
      endcase
    end
  end

  // FSM outputs: decide whether this cycle logs, and where the entry goes.
  always_comb begin
    log_cycle = trace_en && !clear &&
                ((fsm_q == CAPTURE) || ((fsm_q == ARMED) && (pc == trig_pc)));
    log_req   = log_cycle &&
                (every_cyc || first || (state != last_state) || (instr != last_instr));
    full      = (count == FULL_COUNT);
    pop       = (count != '0) && rd_ready && !clear;
    // A simultaneous pop frees a slot, so a full buffer only loses data without one.
    wr_drop   = log_req && full && !pop && !wrap_en;
    wr_over   = log_req && full && !pop &&  wrap_en;
    wr_en     = log_req && !wr_drop;
  end

  // Entry storage.
  // NOTE: the array has no reset; count/rd_valid gate stale contents from view.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ts, state, pc, instr};
  end

  // Pointers, occupancy and loss accounting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else begin
      if (wr_en)          wr_ptr <= wr_ptr + 1'b1;
      // Overwrite-when-full retires the oldest entry just like a pop.
      if (pop || wr_over) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop && !wr_over) count <= count + 1'b1;
      else if (pop && !wr_en)        count <= count - 1'b1;
      if (wr_over || wr_drop) begin
        overflow <= 1'b1;
        if (dropped != 8'hFF) dropped <= dropped + 1'b1;
      end
    end
  end

  // Change detection: last written sample, plus first-sample-since-capture flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first      <= 1'b1;
      last_state <= '0;
      last_instr <= '0;
    end else if (clear) begin
      first <= 1'b1;
    end else if (wr_en) begin
      first      <= 1'b0;
      last_state <= state;
      last_instr <= instr;
    end else if (fsm_q != CAPTURE) begin
      first <= 1'b1;
    end
  end

  assign rd_valid  = (count != '0);
  assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
  assign fsm_state = fsm_q;

endmodule
